// File: rtl/debounce_bank.sv
// debounce_bank
//   Multi-channel push-button conditioner. Each channel has a 2-FF
//   synchroniser, a stability counter that commits the debounced level,
//   one-cycle rise/fall pulses and a long-press / auto-repeat engine.
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   btn_async   raw asynchronous button inputs
//   btn_level   debounced level, 1 = pressed
//   btn_rise    one-cycle pulse on debounced 0->1
//   btn_fall    one-cycle pulse on debounced 1->0
//   btn_repeat  one-cycle long-press / auto-repeat pulse
//   any_level   registered OR of btn_level
//
// Hold/repeat engine states (per channel)
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | debounced level is 0, nothing counting
//   ST_HOLD    | pressed, counting towards the first long-press pulse
//   ST_REPEAT  | long-press issued, pulsing every REPEAT_CYCLES
//   ST_DONE    | single long-press issued (REPEAT_CYCLES = 0), silent

module debounce_bank #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1000,
  parameter int HOLD_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_async,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_rise,
  output logic [CHANNELS-1:0] btn_fall,
  output logic [CHANNELS-1:0] btn_repeat,
  output logic                any_level
);

  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int SCW  = $clog2(STABLE_CYCLES + 1);
  localparam int HCW  = $clog2(HMAX + 1);

  localparam logic [SCW-1:0] S_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [HCW-1:0] H_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [HCW-1:0] R_LAST = HCW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  // Inversion mask applied ahead of the first sync FF so the synchroniser
  // always holds "pressed = 1" and resets to the released value.
  localparam logic [CHANNELS-1:0] POL = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [SCW-1:0]      scnt   [CHANNELS];
  logic [HCW-1:0]      hcnt   [CHANNELS];
  logic [1:0]          hstate [CHANNELS];

  logic [CHANNELS-1:0] differ;
  logic [CHANNELS-1:0] settle;

  // settle marks the edge on which a channel's level flips; it drives the
  // level, the edge pulses and the hold engine so all of them agree.
  always_comb begin
    differ = sync2 ^ btn_level;
    settle = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      settle[i] = differ[i] && (scnt[i] == S_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      btn_level  <= '0;
      btn_rise   <= '0;
      btn_fall   <= '0;
      btn_repeat <= '0;
      any_level  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        scnt[i]   <= '0;
        hcnt[i]   <= '0;
        hstate[i] <= ST_IDLE;
      end
    end else begin
      sync1      <= btn_async ^ POL;
      sync2      <= sync1;
      btn_level  <= btn_level ^ settle;
      btn_rise   <= settle & sync2;
      btn_fall   <= settle & ~sync2;
      any_level  <= |btn_level;
      btn_repeat <= '0;

      for (int i = 0; i < CHANNELS; i++) begin
        // Any sample equal to the current level restarts the stability count.
        if (!differ[i] || settle[i]) begin
          scnt[i] <= '0;
        end else begin
          scnt[i] <= scnt[i] + SCW'(1);
        end

        // A level change overrides the engine, so a repeat never lands on
        // the rise or fall edge itself.
        if (settle[i]) begin
          hcnt[i]   <= '0;
          hstate[i] <= sync2[i] ? ST_HOLD : ST_IDLE;
        end else begin
          case (hstate[i])
            ST_HOLD: begin
              if (hcnt[i] == H_LAST) begin
                btn_repeat[i] <= 1'b1;
                hcnt[i]       <= '0;
                hstate[i]     <= (REPEAT_CYCLES > 0) ? ST_REPEAT : ST_DONE;
              end else begin
                hcnt[i] <= hcnt[i] + HCW'(1);
              end
            end
            ST_REPEAT: begin
              if (hcnt[i] == R_LAST) begin
                btn_repeat[i] <= 1'b1;
                hcnt[i]       <= '0;
              end else begin
                hcnt[i] <= hcnt[i] + HCW'(1);
              end
            end
            default: begin
              hcnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule
